// File: rtl/dff_bank_rr_arbiter_pkg.sv
// Shared definitions for the round-robin register-bank arbiter:
// default widths, FSM encodings and a one-hot helper.
package dff_bank_rr_arbiter_pkg;

    localparam int DEF_N_REQ  = 4;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CNT_W  = 16;
    localparam int MAX_REQ    = 8;
    localparam int ID_W       = 3;

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_ACTIVE = 1'b1;

    function automatic logic [MAX_REQ-1:0] onehot8(input logic [ID_W-1:0] idx);
        return MAX_REQ'(1) << idx;
    endfunction

endpackage

// File: rtl/dff_bank_rr_arbiter_if.sv
// Requester-side bus of the arbiter.
// master: drives en/req/wdata; slave (arbiter): drives grant/q/q_valid/last_id/wr_cnt.
interface dff_bank_rr_arbiter_if #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic                    en;
    logic [N_REQ-1:0]        req;
    logic [N_REQ*DATA_W-1:0] wdata;
    logic [N_REQ-1:0]        grant;
    logic [DATA_W-1:0]       q;
    logic                    q_valid;
    logic [2:0]              last_id;
    logic [CNT_W-1:0]        wr_cnt;

    modport master (
        output en, req, wdata,
        input  grant, q, q_valid, last_id, wr_cnt
    );

    modport slave (
        input  en, req, wdata,
        output grant, q, q_valid, last_id, wr_cnt
    );
endinterface

// File: rtl/dff_bank_rr_arbiter_rr_pick.sv
// Combinational round-robin pick: rotate elig by ptr, priority-encode.
// in: elig, ptr; out: win (requester index), valid (any eligible).
module dff_bank_rr_arbiter_rr_pick
    import dff_bank_rr_arbiter_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ
)(
    input  logic [N_REQ-1:0] elig,
    input  logic [ID_W-1:0]  ptr,
    output logic [ID_W-1:0]  win,
    output logic             valid
);
    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [ID_W-1:0]    off;
    logic [ID_W:0]      sum;

    // Bit j of rot is requester (ptr+j) mod N_REQ.
    assign dbl   = {elig, elig};
    assign rot   = dbl[ptr +: N_REQ];
    assign valid = |elig;

    always_comb begin
        off = '0;
        for (int j = N_REQ - 1; j >= 0; j--) begin
            if (rot[j]) off = ID_W'(j);
        end
        sum = {1'b0, ptr} + {1'b0, off};
        if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
        win = sum[ID_W-1:0];
    end
endmodule

// File: rtl/dff_bank_rr_arbiter.sv
// Round-robin arbiter sharing one DATA_W register among N_REQ requesters.
// clk/rst (async, active-high) plus slave bus: en/req/wdata in; grant/q/q_valid/last_id/wr_cnt out.
module dff_bank_rr_arbiter
    import dff_bank_rr_arbiter_pkg::*;
#(
    parameter int N_REQ  = DEF_N_REQ,
    parameter int DATA_W = DEF_DATA_W,
    parameter int CNT_W  = DEF_CNT_W
)(
    input  logic                 clk,
    input  logic                 rst,
    dff_bank_rr_arbiter_if.slave bus
);
    logic [N_REQ-1:0]   elig;
    logic [ID_W-1:0]    win;
    logic [ID_W-1:0]    ptr;
    logic               win_v;
    logic               go;
    logic [0:0]         state;
    logic [MAX_REQ-1:0] oh;

    // The requester granted this cycle is masked so a held req
    // cannot be served twice in a row.
    assign elig = bus.req & ~bus.grant;
    assign go   = bus.en & win_v;
    assign oh   = onehot8(win);

    // ACTIVE exactly when the last edge wrote q.
    assign bus.q_valid = (state == ST_ACTIVE);

    dff_bank_rr_arbiter_rr_pick #(.N_REQ(N_REQ)) u_pick (
        .elig  (elig),
        .ptr   (ptr),
        .win   (win),
        .valid (win_v)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            ptr         <= '0;
            bus.grant   <= '0;
            bus.q       <= '0;
            bus.last_id <= '0;
            bus.wr_cnt  <= '0;
        end else begin
            state     <= go ? ST_ACTIVE : ST_IDLE;
            bus.grant <= go ? oh[N_REQ-1:0] : '0;
            if (go) begin
                bus.q       <= bus.wdata[int'(win)*DATA_W +: DATA_W];
                bus.last_id <= win;
                bus.wr_cnt  <= bus.wr_cnt + CNT_W'(1);
                ptr         <= (win == ID_W'(N_REQ-1)) ? '0 : win + ID_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_dff_bank_rr_arbiter.sv
// Testbench for dff_bank_rr_arbiter: directed table, hand sequences,
// and randomized traffic against a behavioural model.
module tb_dff_bank_rr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [3:0]  req;
    logic [31:0] wdata;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dff_bank_rr_arbiter_if #(.N_REQ(4), .DATA_W(8), .CNT_W(16)) bus ();
    dff_bank_rr_arbiter_if #(.N_REQ(4), .DATA_W(8), .CNT_W(4))  bus4 ();

    assign bus.en     = en;
    assign bus.req    = req;
    assign bus.wdata  = wdata;
    assign bus4.en    = en;
    assign bus4.req   = req;
    assign bus4.wdata = wdata;

    dff_bank_rr_arbiter #(.N_REQ(4), .DATA_W(8), .CNT_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    dff_bank_rr_arbiter #(.N_REQ(4), .DATA_W(8), .CNT_W(4)) dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4)
    );

    // Behavioural model: linear search for the first eligible
    // requester starting at the fairness pointer.
    function automatic int pick(input logic [3:0] el, input int p);
        for (int k = 0; k < 4; k++) begin
            if (el[(p + k) % 4]) return (p + k) % 4;
        end
        return -1;
    endfunction

    logic [3:0] m_grant;
    logic [7:0] m_q;
    logic       m_qv;
    int         m_last;
    int         m_cnt;
    int         m_ptr;
    int         m_win;

    assign m_win = pick(req & ~m_grant, m_ptr);

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_grant <= '0;
            m_q     <= '0;
            m_qv    <= 1'b0;
            m_last  <= 0;
            m_cnt   <= 0;
            m_ptr   <= 0;
        end else if (en && m_win >= 0) begin
            m_grant <= 4'(1 << m_win);
            m_q     <= wdata[m_win*8 +: 8];
            m_qv    <= 1'b1;
            m_last  <= m_win;
            m_cnt   <= m_cnt + 1;
            m_ptr   <= (m_win + 1) % 4;
        end else begin
            m_grant <= '0;
            m_qv    <= 1'b0;
        end
    end

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " grant"}, int'(bus.grant), 0);
        chk({tag, " q"}, int'(bus.q), 0);
        chk({tag, " q_valid"}, int'(bus.q_valid), 0);
        chk({tag, " last_id"}, int'(bus.last_id), 0);
        chk({tag, " wr_cnt"}, int'(bus.wr_cnt), 0);
        chk({tag, " wr_cnt4"}, int'(bus4.wr_cnt), 0);
    endtask

    task automatic chk_model(input string tag);
        chk({tag, " grant"}, int'(bus.grant), int'(m_grant));
        chk({tag, " q"}, int'(bus.q), int'(m_q));
        chk({tag, " q_valid"}, int'(bus.q_valid), int'(m_qv));
        chk({tag, " last_id"}, int'(bus.last_id), m_last);
        chk({tag, " wr_cnt"}, int'(bus.wr_cnt), m_cnt % 65536);
        chk({tag, " wr_cnt4"}, int'(bus4.wr_cnt), m_cnt % 16);
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    typedef struct {
        bit          do_rst;
        bit          en;
        logic [3:0]  req;
        logic [31:0] wdata;
        logic [3:0]  g;
        logic [7:0]  q;
        bit          qv;
        int          lid;
        int          cnt;
    } vec_t;

    vec_t vecs[$];

    localparam logic [31:0] W1 = 32'h44332211;
    localparam logic [31:0] W2 = 32'h44A52211;

    initial begin
        // rotation
        vecs.push_back(vec_t'{0, 1, 4'b1111, W1, 4'b0001, 8'h11, 1, 0, 1});
        vecs.push_back(vec_t'{0, 1, 4'b1111, W1, 4'b0010, 8'h22, 1, 1, 2});
        vecs.push_back(vec_t'{0, 1, 4'b1111, W1, 4'b0100, 8'h33, 1, 2, 3});
        vecs.push_back(vec_t'{0, 1, 4'b1111, W1, 4'b1000, 8'h44, 1, 3, 4});
        vecs.push_back(vec_t'{0, 1, 4'b1111, W1, 4'b0001, 8'h11, 1, 0, 5});
        // single requester
        vecs.push_back(vec_t'{1, 1, 4'b0100, W2, 4'b0100, 8'hA5, 1, 2, 1});
        vecs.push_back(vec_t'{0, 1, 4'b0100, W2, 4'b0000, 8'hA5, 0, 2, 1});
        vecs.push_back(vec_t'{0, 1, 4'b0100, W2, 4'b0100, 8'hA5, 1, 2, 2});
        vecs.push_back(vec_t'{0, 1, 4'b0100, W2, 4'b0000, 8'hA5, 0, 2, 2});
        // enable gating
        vecs.push_back(vec_t'{1, 1, 4'b1111, W1, 4'b0001, 8'h11, 1, 0, 1});
        vecs.push_back(vec_t'{0, 1, 4'b1111, W1, 4'b0010, 8'h22, 1, 1, 2});
        vecs.push_back(vec_t'{0, 0, 4'b1111, W1, 4'b0000, 8'h22, 0, 1, 2});
        vecs.push_back(vec_t'{0, 0, 4'b1111, W1, 4'b0000, 8'h22, 0, 1, 2});
        vecs.push_back(vec_t'{0, 0, 4'b1111, W1, 4'b0000, 8'h22, 0, 1, 2});
        vecs.push_back(vec_t'{0, 1, 4'b1111, W1, 4'b0100, 8'h33, 1, 2, 3});
        vecs.push_back(vec_t'{0, 1, 4'b1111, W1, 4'b1000, 8'h44, 1, 3, 4});

        // reset held from time 0 with all requests up
        rst   = 1'b1;
        en    = 1'b1;
        req   = 4'b1111;
        wdata = W1;
        #8;
        chk_zero("reset");
        #4;
        rst = 1'b0;

        foreach (vecs[i]) begin
            if (vecs[i].do_rst) pulse_rst();
            en    = vecs[i].en;
            req   = vecs[i].req;
            wdata = vecs[i].wdata;
            @(posedge clk);
            @(negedge clk);
            chk($sformatf("vec%0d grant", i), int'(bus.grant), int'(vecs[i].g));
            chk($sformatf("vec%0d q", i), int'(bus.q), int'(vecs[i].q));
            chk($sformatf("vec%0d q_valid", i), int'(bus.q_valid), int'(vecs[i].qv));
            chk($sformatf("vec%0d last_id", i), int'(bus.last_id), vecs[i].lid);
            chk($sformatf("vec%0d wr_cnt", i), int'(bus.wr_cnt), vecs[i].cnt);
            chk($sformatf("vec%0d wr_cnt4", i), int'(bus4.wr_cnt), vecs[i].cnt % 16);
        end

        // counter wrap: 17 grants on the 4-bit counter
        pulse_rst();
        en    = 1'b1;
        req   = 4'b1111;
        wdata = W1;
        repeat (17) @(posedge clk);
        @(negedge clk);
        chk("wrap wr_cnt4", int'(bus4.wr_cnt), 1);
        chk("wrap wr_cnt", int'(bus.wr_cnt), 17);

        // async reset in the middle of a grant cycle
        @(posedge clk);
        #1;
        chk("mid grant before rst", int'(bus.grant), int'(m_grant));
        #3;
        rst = 1'b1;
        #1;
        chk_zero("mid rst");
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("post rst grant", int'(bus.grant), 1);

        // randomized traffic against the model
        for (int n = 0; n < 400; n++) begin
            en    = ($urandom_range(0, 9) != 0);
            req   = 4'($urandom_range(0, 15));
            wdata = $urandom;
            @(posedge clk);
            @(negedge clk);
            chk_model($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
